fpu_issue_ctrl: RTL
===================

// Module: fpu_issue_ctrl
// PURPOSE
//  Parametrised issue/completion controller for the FPU's fixed-latency functional units (add/sub,
//  mul, div, sqrt, compare, convert, sign-inject/min/max). Accepts one op via valid/ready, drives
//  that unit's clock enable for exactly its latency and captures result plus exception flags.
//  Accumulates sticky RISC-V fflags. Sits between EX-stage decode and the unit instances.
//  Replaces the free-running, unhandshaked result mux with stall-safe sequencing.
// PARAMETERS
//  WIDTH     32               operand/result width
//  NUNITS    8                number of attached functional units
//  UIDW      3                unit-select width, >= clog2(NUNITS)
//  TAGW      5                destination tag width (rd index), carried through unchanged
//  LATW      5                latency field width per unit
//  LAT_TABLE {8 x LATW} pkg   packed per-unit latency; unit i at [i*LATW +: LATW]; 0 = combinational
// PORTS
//  clock        in   1              rising-edge clock
//  clear        in   1              synchronous reset, active-low
//  flush        in   1              abort in-flight op (branch/trap)
//  in_valid     in   1              op request
//  in_ready     out  1              op accepted when in_valid & in_ready
//  in_unit      in   UIDW           target unit index
//  in_tag       in   TAGW           destination tag
//  in_a, in_b   in   WIDTH each     operands
//  op_a, op_b   out  WIDTH each     registered operands to all units, stable while busy
//  unit_en      out  NUNITS         per-unit clk_en, one-hot or zero
//  unit_result  in   NUNITS*WIDTH   unit i result at [i*WIDTH +: WIDTH]
//  unit_flags   in   NUNITS*5       unit i {NV,DZ,OF,UF,NX} at [i*5 +: 5]
//  out_valid    out  1              completed result available
//  out_ready    in   1              consumer takes result
//  out_result   out  WIDTH          captured result
//  out_tag      out  TAGW           tag of completed op
//  out_flags    out  5              flags of completed op
//  fflags       out  5              sticky accumulated flags (CSR view)
//  fflags_clr   in   1              CSR write clears fflags
//  busy         out  1              state != IDLE
// BEHAVIOUR
//  - Reset (clear=0 at edge): state IDLE; in_ready=1; unit_en=0, out_valid=0, busy=0;
//    out_result/out_tag/out_flags/op_a/op_b/fflags=0. Reset overrides every other input.
//  - FSM IDLE -> EXEC -> DONE. in_ready = IDLE | (DONE & out_ready); accept in DONE is back-to-back.
//  - Accept edge: latch in_a/in_b->op_a/op_b, in_unit->sel, in_tag, cnt<=LAT_TABLE[sel]; go EXEC.
//  - EXEC: unit_en[sel]=1 while cnt!=0; cnt decrements each cycle. When cnt==0, next edge captures
//    unit_result[sel], unit_flags[sel] into out_*, goes DONE. out_valid rises LAT+1 edges after
//    accept (LAT=0 -> 1 edge). unit_en never asserted in IDLE/DONE or for unselected units.
//  - DONE: out_* held stable while out_valid & ~out_ready. On out_ready: fflags |= out_flags; then
//    IDLE, or EXEC if a new op is accepted the same edge.
//  - in_unit >= NUNITS: no unit_en; completes 1 edge later with out_result=0, out_flags=NV(10000).
//  - fflags_clr & flag-merge same edge: clear first, new flags kept (fflags = out_flags).
//  - flush: next edge -> IDLE, out_valid=0, unit_en=0, no fflags update; flush with in_valid
//    drops the request (in_ready forced 0 while flush=1). fflags_clr still honoured.
//  - Flag bits: NV=4 DZ=3 OF=2 UF=1 NX=0 (RISC-V order).
// STRUCTURE
//  - Shared package fpu_pkg: flag bit positions, unit index constants (FPU_U_ADD=0, MUL=1, DIV=2,
//    SQRT=3, CMP=4, CVT_F2I=5, CVT_I2F=6, SGNJ=7), default LAT_TABLE {0,6,6,1,16,6,5,7} (unit 7..0).
//  - One sub-module: fpu_fflags_reg (sticky flags, clear-then-set priority). Rest is flat FSM.
// TESTING
//  - Bench models each unit as a clk_en-gated pipeline of its LAT_TABLE depth.
//  - ADD 0x3F800000+0x40000000 tag 5 -> unit_en[0] high 7 cycles, out_valid at edge 8,
//    out_result 0x40400000, out_tag 5; fflags unchanged (flags 0).
//  - DIV 1.0/0.0 (unit flags DZ) with out_ready low 3 cycles -> outputs stable, then fflags=01000;
//    next SQRT(-1.0) NV -> fflags=11000; fflags_clr same edge as NV merge -> fflags=10000.
//  - Back-to-back: SGNJ (LAT 0) accepted in DONE of a MUL with out_ready=1 -> no idle bubble,
//    SGNJ out_valid 1 edge after accept.
//  - flush at cycle 3 of SQRT -> busy=0 next edge, no out_valid, unit_en[3] drops, fflags kept.
//  - in_unit=3'd7 with NUNITS=7 -> out_valid after 1 edge, result 0, out_flags 10000;
//    clear=0 mid-EXEC -> all outputs reset values next edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag layout, functional-unit indices,
// default per-unit latencies and the issue-controller state encoding.
package fpu_pkg;

    localparam int FPU_FLAGW = 5;

    // RISC-V fflags order, MSB first: {NV, DZ, OF, UF, NX}
    localparam int FPU_FLAG_NV = 4;
    localparam int FPU_FLAG_DZ = 3;
    localparam int FPU_FLAG_OF = 2;
    localparam int FPU_FLAG_UF = 1;
    localparam int FPU_FLAG_NX = 0;

    localparam logic [FPU_FLAGW-1:0] FPU_FLAGS_NONE = 5'b00000;
    localparam logic [FPU_FLAGW-1:0] FPU_FLAGS_NV   = 5'b10000;

    localparam int FPU_U_ADD     = 0;
    localparam int FPU_U_MUL     = 1;
    localparam int FPU_U_DIV     = 2;
    localparam int FPU_U_SQRT    = 3;
    localparam int FPU_U_CMP     = 4;
    localparam int FPU_U_CVT_F2I = 5;
    localparam int FPU_U_CVT_I2F = 6;
    localparam int FPU_U_SGNJ    = 7;

    localparam int FPU_NUNITS_DEFAULT = 8;
    localparam int FPU_LATW_DEFAULT   = 5;

    // Packed latencies, unit 7 in the top field down to unit 0 in the bottom field.
    localparam logic [FPU_NUNITS_DEFAULT*FPU_LATW_DEFAULT-1:0] FPU_LAT_TABLE_DEFAULT =
        {5'd0, 5'd6, 5'd6, 5'd1, 5'd16, 5'd6, 5'd5, 5'd7};

    typedef enum logic [1:0] {
        FPU_IDLE = 2'd0,
        FPU_EXEC = 2'd1,
        FPU_DONE = 2'd2
    } fpu_state_e;

endpackage

// File: rtl/fpu_fflags_reg.sv
// Sticky accrued-exception register behind the fflags CSR.
// A CSR clear coinciding with a flag merge drops the old flags but keeps the new ones.
module fpu_fflags_reg
    import fpu_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 clr,
    input  logic                 set_en,
    input  logic [FPU_FLAGW-1:0] set_flags,
    output logic [FPU_FLAGW-1:0] fflags
);

    // Accrue completed-op flags; clear has priority over the old value only.
    always_ff @(posedge clock) begin
        if (!clear) begin
            fflags <= '0;
        end else if (set_en) begin
            fflags <= (clr ? '0 : fflags) | set_flags;
        end else if (clr) begin
            fflags <= '0;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/completion sequencer for the fixed-latency FPU functional units.
// One op at a time: accept, clock-enable the selected unit for its latency,
// capture result and flags, hold them until the consumer takes them.
//
// state | meaning
// IDLE  | no op in flight, ready for a request
// EXEC  | op issued; unit_en[sel] high while cnt != 0, capture when cnt == 0
// DONE  | result held on out_*; a new op may be accepted on the consume edge
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUNITS = 8,
    parameter int UIDW   = 3,
    parameter int TAGW   = 5,
    parameter int LATW   = 5,
    parameter logic [NUNITS*LATW-1:0] LAT_TABLE = FPU_LAT_TABLE_DEFAULT[NUNITS*LATW-1:0]
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UIDW-1:0]             in_unit,
    input  logic [TAGW-1:0]             in_tag,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic [WIDTH-1:0]            op_a,
    output logic [WIDTH-1:0]            op_b,
    output logic [NUNITS-1:0]           unit_en,
    input  logic [NUNITS*WIDTH-1:0]     unit_result,
    input  logic [NUNITS*FPU_FLAGW-1:0] unit_flags,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_result,
    output logic [TAGW-1:0]             out_tag,
    output logic [FPU_FLAGW-1:0]        out_flags,
    output logic [FPU_FLAGW-1:0]        fflags,
    input  logic                        fflags_clr,
    output logic                        busy
);

    fpu_state_e             state;
    logic [UIDW-1:0]        sel;
    logic [TAGW-1:0]        tag_q;
    logic [LATW-1:0]        cnt;

    logic                   accept;
    logic                   merge;
    logic [NUNITS-1:0]      acc_mask;
    logic [LATW-1:0]        acc_lat;
    logic [NUNITS-1:0]      sel_mask;
    logic [WIDTH-1:0]       cur_result;
    logic [FPU_FLAGW-1:0]   cur_flags;

    // A flush suppresses acceptance so the aborting cycle cannot start a new op.
    assign in_ready = ~flush & ((state == FPU_IDLE) | ((state == FPU_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign merge    = (state == FPU_DONE) & out_ready & ~flush;

    // Decode the requested unit; an index past NUNITS matches nothing and gets latency 0.
    always_comb begin
        acc_mask = '0;
        acc_lat  = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (in_unit == UIDW'(i)) begin
                acc_mask[i] = 1'b1;
                acc_lat     = LAT_TABLE[i*LATW +: LATW];
            end
        end
    end

    // Select the in-flight unit's outputs; a non-existent unit completes as 0 with NV.
    always_comb begin
        sel_mask   = '0;
        cur_result = '0;
        cur_flags  = FPU_FLAGS_NV;
        for (int i = 0; i < NUNITS; i++) begin
            if (sel == UIDW'(i)) begin
                sel_mask[i] = 1'b1;
                cur_result  = unit_result[i*WIDTH +: WIDTH];
                cur_flags   = unit_flags[i*FPU_FLAGW +: FPU_FLAGW];
            end
        end
    end

    // Issue FSM with registered outputs; accept covers both IDLE and the DONE consume edge.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= FPU_IDLE;
            sel        <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            unit_en    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state     <= FPU_IDLE;
            unit_en   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= FPU_EXEC;
            sel       <= in_unit;
            tag_q     <= in_tag;
            cnt       <= acc_lat;
            op_a      <= in_a;
            op_b      <= in_b;
            unit_en   <= (acc_lat != '0) ? acc_mask : '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                FPU_EXEC: begin
                    if (cnt == '0) begin
                        state      <= FPU_DONE;
                        unit_en    <= '0;
                        out_valid  <= 1'b1;
                        out_result <= cur_result;
                        out_tag    <= tag_q;
                        out_flags  <= cur_flags;
                    end else begin
                        cnt     <= cnt - LATW'(1);
                        unit_en <= (cnt == LATW'(1)) ? '0 : sel_mask;
                    end
                end
                FPU_DONE: begin
                    if (out_ready) begin
                        state     <= FPU_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= FPU_IDLE;
                end
            endcase
        end
    end

    fpu_fflags_reg u_fflags (
        .clock     (clock),
        .clear     (clear),
        .clr       (fflags_clr),
        .set_en    (merge),
        .set_flags (out_flags),
        .fflags    (fflags)
    );

endmodule
